// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state encodings and default widths for the data memory responder
package mem_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_RD_WAIT = 2'd1, S_RD_DONE = 2'd2;
endpackage

// File: rtl/data_mem_resp_if.sv
// data_mem_resp_if: execute-stage memory bus; master drives strobes/addr/wdata/dbg_addr, slave returns rdata/rdata_valid/stall/req_err/dbg_rdata
interface data_mem_resp_if import mem_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          stall;
  logic          req_err;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_rdata;
  modport master (
    output mem_read, mem_write, addr, wdata, dbg_addr,
    input  rdata, rdata_valid, stall, req_err, dbg_rdata
  );
  modport slave (
    input  mem_read, mem_write, addr, wdata, dbg_addr,
    output rdata, rdata_valid, stall, req_err, dbg_rdata
  );
endinterface

// File: rtl/data_ram.sv
// data_ram: 2**ADDR_W x DATA_W RAM, sync write port (clk, we, waddr, wdata), comb load port (raddr->rdata) and debug port (daddr->ddata)
module data_ram import mem_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] daddr,
  output logic [DW-1:0] ddata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
  assign ddata = mem[daddr];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: load/store responder with RD_LAT-cycle load latency and pipeline stall; ports clock, reset (async high), bus (slave modport)
module data_mem_resp import mem_pkg::*; #(
  parameter int DW     = DATA_W,
  parameter int AW     = ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  data_mem_resp_if.slave bus
);
  logic [1:0]    state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          req_err_q, req_err_d;
  logic          accepting, ld, st, both;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  assign accepting = (state_q == S_IDLE) || (state_q == S_RD_DONE);
  assign ld        = accepting && bus.mem_read && !bus.mem_write;
  assign st        = accepting && bus.mem_write && !bus.mem_read;
  assign both      = accepting && bus.mem_read && bus.mem_write;
  // with RD_LAT==1 the load enters RD_DONE on its accepting edge, so read the live address
  assign ram_raddr = ld ? bus.addr : addr_q;
  data_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clock),
    .we    (st),
    .waddr (bus.addr),
    .wdata (bus.wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .daddr (bus.dbg_addr),
    .ddata (bus.dbg_rdata)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      addr_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      req_err_q     <= req_err_d;
    end
  always_comb begin
    state_d = ld ? (RD_LAT == 1 ? S_RD_DONE : S_RD_WAIT)
            : accepting ? S_IDLE
            : (count_q == 3'd1 ? S_RD_DONE : S_RD_WAIT);
    count_d = ld ? 3'(RD_LAT - 1) : (state_q == S_RD_WAIT ? count_q - 3'd1 : count_q);
    addr_d  = ld ? bus.addr : addr_q;
  end
  always_comb begin
    rdata_valid_d = (state_d == S_RD_DONE);
    rdata_d       = rdata_valid_d ? ram_rdata : rdata_q;
    req_err_d     = both;
  end
  assign bus.stall       = (state_q == S_RD_WAIT) || ld;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.req_err     = req_err_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for data_mem_resp at RD_LAT=2 and RD_LAT=1
module tb_data_mem_resp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] exp1_q [$];
  data_mem_resp_if #(.DW(8), .AW(8)) bus ();
  data_mem_resp_if #(.DW(8), .AW(8)) bus1 ();
  data_mem_resp #(.DW(8), .AW(8), .RD_LAT(2)) dut (.clock(clk), .reset(reset), .bus(bus));
  data_mem_resp #(.DW(8), .AW(8), .RD_LAT(1)) dut1 (.clock(clk), .reset(reset), .bus(bus1));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!reset && bus.rdata_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_valid rdata=%h", bus.rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rdata !== e) begin
          fails++;
          $display("FAIL sb_rdata got=%h exp=%h", bus.rdata, e);
        end
      end
    end
  always @(negedge clk)
    if (!reset && bus1.rdata_valid) begin
      tests++;
      if (exp1_q.size() == 0) begin
        fails++;
        $display("FAIL sb1_unexpected_valid rdata=%h", bus1.rdata);
      end else begin
        logic [7:0] e;
        e = exp1_q.pop_front();
        if (bus1.rdata !== e) begin
          fails++;
          $display("FAIL sb1_rdata got=%h exp=%h", bus1.rdata, e);
        end
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
  endtask
  task automatic store(input logic [7:0] a, input logic [7:0] d);
    cyc();
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    model[a] = d;
    cyc();
    idle();
  endtask
  task automatic test_reset();
    #3;
    tests++;
    if (bus.rdata !== 8'h00 || bus.rdata_valid !== 1'b0 || bus.req_err !== 1'b0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs rdata=%h valid=%b err=%b stall=%b exp 00/0/0/0", bus.rdata, bus.rdata_valid, bus.req_err, bus.stall);
    end
    #4 reset = 1'b0;
  endtask
  task automatic test_store_load();
    store(8'h10, 8'hA5);
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL store_no_stall stall=%b exp 0", bus.stall);
    end
    bus.mem_read = 1'b1;
    bus.addr = 8'h10;
    exp_q.push_back(model[8'h10]);
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b1 || bus.rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL sl_req_cycle stall=%b valid=%b exp 1/0", bus.stall, bus.rdata_valid);
    end
    cyc();
    idle();
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b1 || bus.rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL sl_wait_cycle stall=%b valid=%b exp 1/0", bus.stall, bus.rdata_valid);
    end
    cyc();
    @(negedge clk);
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 8'hA5 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL sl_done valid=%b rdata=%h stall=%b exp 1/a5/0", bus.rdata_valid, bus.rdata, bus.stall);
    end
    cyc();
    @(negedge clk);
    tests++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== 8'hA5) begin
      fails++;
      $display("FAIL sl_hold valid=%b rdata=%h exp 0/a5", bus.rdata_valid, bus.rdata);
    end
  endtask
  task automatic test_back_to_back();
    store(8'h03, 8'h11);
    store(8'h04, 8'h22);
    bus.mem_read = 1'b1;
    bus.addr = 8'h03;
    exp_q.push_back(model[8'h03]);
    cyc();
    idle();
    cyc();
    bus.mem_read = 1'b1;
    bus.addr = 8'h04;
    exp_q.push_back(model[8'h04]);
    @(negedge clk);
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 8'h11 || bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first valid=%b rdata=%h stall=%b exp 1/11/1", bus.rdata_valid, bus.rdata, bus.stall);
    end
    cyc();
    idle();
    @(negedge clk);
    tests++;
    if (bus.rdata_valid !== 1'b0 || bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL b2b_gap valid=%b stall=%b exp 0/1", bus.rdata_valid, bus.stall);
    end
    cyc();
    @(negedge clk);
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 8'h22) begin
      fails++;
      $display("FAIL b2b_second valid=%b rdata=%h exp 1/22", bus.rdata_valid, bus.rdata);
    end
  endtask
  task automatic test_both();
    store(8'h20, 8'h3C);
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr = 8'h20;
    bus.wdata = 8'hFF;
    bus.dbg_addr = 8'h20;
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL both_req_stall stall=%b exp 0", bus.stall);
    end
    cyc();
    idle();
    @(negedge clk);
    tests++;
    if (bus.req_err !== 1'b1 || bus.rdata_valid !== 1'b0 || bus.stall !== 1'b0 || bus.dbg_rdata !== model[8'h20]) begin
      fails++;
      $display("FAIL both_err err=%b valid=%b stall=%b dbg=%h exp 1/0/0/%h", bus.req_err, bus.rdata_valid, bus.stall, bus.dbg_rdata, model[8'h20]);
    end
    cyc();
    @(negedge clk);
    tests++;
    if (bus.req_err !== 1'b0) begin
      fails++;
      $display("FAIL both_pulse err=%b exp 0", bus.req_err);
    end
  endtask
  task automatic test_ignored_wrap();
    store(8'hFF, 8'h77);
    bus.mem_read = 1'b1;
    bus.addr = 8'h03;
    exp_q.push_back(model[8'h03]);
    cyc();
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr = 8'hFF;
    bus.wdata = 8'h5A;
    bus.dbg_addr = 8'hFF;
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL ign_stall stall=%b exp 1", bus.stall);
    end
    cyc();
    idle();
    @(negedge clk);
    tests++;
    if (bus.dbg_rdata !== model[8'hFF]) begin
      fails++;
      $display("FAIL ign_unchanged dbg=%h exp %h", bus.dbg_rdata, model[8'hFF]);
    end
    store(8'hFF, 8'h5A);
    @(negedge clk);
    tests++;
    if (bus.dbg_rdata !== 8'h5A) begin
      fails++;
      $display("FAIL wrap_store dbg=%h exp 5a", bus.dbg_rdata);
    end
  endtask
  task automatic test_reset_mid_read();
    cyc();
    bus.mem_read = 1'b1;
    bus.addr = 8'h04;
    cyc();
    idle();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (bus.rdata !== 8'h00 || bus.rdata_valid !== 1'b0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset rdata=%h valid=%b stall=%b exp 00/0/0", bus.rdata, bus.rdata_valid, bus.stall);
    end
    #9 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rdata_valid !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_no_valid cycle=%0d valid=%b exp 0", i, bus.rdata_valid);
      end
    end
  endtask
  task automatic test_lat1();
    cyc();
    bus1.mem_write = 1'b1;
    bus1.addr = 8'h07;
    bus1.wdata = 8'h99;
    cyc();
    bus1.mem_write = 1'b0;
    bus1.mem_read = 1'b1;
    exp1_q.push_back(8'h99);
    @(negedge clk);
    tests++;
    if (bus1.stall !== 1'b1) begin
      fails++;
      $display("FAIL lat1_req_stall stall=%b exp 1", bus1.stall);
    end
    cyc();
    bus1.mem_read = 1'b0;
    @(negedge clk);
    tests++;
    if (bus1.rdata_valid !== 1'b1 || bus1.rdata !== 8'h99 || bus1.stall !== 1'b0) begin
      fails++;
      $display("FAIL lat1_done valid=%b rdata=%h stall=%b exp 1/99/0", bus1.rdata_valid, bus1.rdata, bus1.stall);
    end
    cyc();
    @(negedge clk);
    tests++;
    if (bus1.rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL lat1_pulse valid=%b exp 0", bus1.rdata_valid);
    end
  endtask
  initial begin
    idle();
    bus.addr = '0;
    bus.wdata = '0;
    bus.dbg_addr = '0;
    bus1.mem_read = 1'b0;
    bus1.mem_write = 1'b0;
    bus1.addr = '0;
    bus1.wdata = '0;
    bus1.dbg_addr = '0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_both();
    test_ignored_wrap();
    test_reset_mid_read();
    test_lat1();
    cyc();
    cyc();
    tests++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      fails++;
      $display("FAIL sb_pending left=%0d/%0d exp 0/0", exp_q.size(), exp1_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
